vme_master_transfer: RTL and testbench
======================================

# vme_master_transfer

VME master data-transfer sequencer for the k30p controller. It sits downstream of the address decoder and the VME bus arbiter. When the 68030 addresses a VME space and the bus has been acquired, it runs one D16 VME master cycle (A16/A24/A40) and drives the VME strobes, address modifier and transceiver enables. It returns DSACK or bus error to the CPU and releases the bus strobes cleanly before the next cycle.

## Interface
Parameters:
- ADDR_SETUP_CYCLES, 2: clocks address/AM/WRITE are driven before AS asserts (1..7).
- TIMEOUT_CYCLES, 255: clocks in WAIT_ACK before a bus error is generated (8-bit counter).

Ports (active-low unless noted):
- clock  input  1  CPU clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- request_vme_a16 / request_vme_a24 / request_vme_a40  input  1 each  active-high space selects from the address decoder; at most one is set.
- bus_acquired  input  1  active-high; the arbiter owns the VME bus.
- cpu_as, cpu_ds, cpu_write  input  1  68030 strobes; cpu_write is high for read.
- cpu_siz  input  2  68030 SIZ.
- cpu_address  input  2  A1:A0.
- cpu_fc  input  3  function code.
- vme_dtack, vme_berr  input  1  asynchronous VME responses.
- cpu_dsack  output  2  DSACK1:DSACK0.
- cpu_berr  output  1  bus error to the CPU.
- vme_drive  output  1  active-high; enables the tristate drivers for the master signals.
- vme_as_out  output  1
- vme_ds_out  output  2  DS1:DS0.
- vme_lword_out  output  1
- vme_write_out  output  1
- vme_address_mod_out  output  6
- addr_low_oe  output  1
- a40_cross_oe  output  1
- d16_cross_oe  output  1
- d16_cross_dir  output  1  high drives CPU to VME.
- transfer_active  output  1  active-high; the arbiter must hold BBSY while it is set.

## Operation
- dtack and berr each pass through a 2-flop synchronizer; only the synced copies are used.
- FSM states:
  - IDLE: start when cpu_as is low and any request is set; go to WAIT_BUS.
  - WAIT_BUS: go to ADDR when bus_acquired is set.
  - ADDR: drive address, AM and WRITE; count ADDR_SETUP_CYCLES, then go to STROBE.
  - STROBE: assert AS; go to WAIT_ACK on the next clock, where DS asserts.
  - WAIT_ACK:
    - synced berr low: go to ERROR.
    - else synced dtack low: go to ACK.
    - else counter reaches TIMEOUT_CYCLES: go to ERROR.
  - ACK: assert cpu_dsack=2'b01 (16-bit port).
  - ERROR: assert cpu_berr=0.
  - ACK and ERROR both hold DS and AS until cpu_as is high, then go to RELEASE.
  - RELEASE: negate AS and DS; wait until synced dtack and berr are both high, then go to IDLE.
- If cpu_as goes high in WAIT_BUS, ADDR, STROBE or WAIT_ACK, the cycle is aborted and the FSM goes to RELEASE.
- Address modifier, from cpu_fc (5 supervisor data, 6 supervisor program, 1 user data, 2 user program):
  - A16: 0x2D supervisor, 0x29 user.
  - A24: 0x3D, 0x3E, 0x39, 0x3A respectively.
  - A40: 0x34.
  - Any other fc: supervisor data code.
- Data strobes:
  - A0=1: DS0 only.
  - A0=0 and cpu_siz=01 (byte): DS1 only.
  - A0=0 and any other size: DS1 and DS0.
  - vme_lword_out is always high.
- Transceivers:
  - addr_low_oe is low from ADDR through RELEASE.
  - a40_cross_oe is low in the same states, only for A40.
  - d16_cross_oe is low from ADDR through RELEASE for writes, and from WAIT_ACK through RELEASE for reads.
  - d16_cross_dir = ~cpu_write, latched in ADDR.
- vme_drive and transfer_active are high from ADDR through RELEASE.
- Space, write, AM and DS encodings are latched on entry to ADDR and held until IDLE.

## Timing
- Reset and IDLE values:
  - cpu_dsack=2'b11, cpu_berr=1, vme_as_out=1, vme_ds_out=2'b11, vme_lword_out=1, vme_write_out=1.
  - vme_address_mod_out=6'h3F, all *_oe=1, d16_cross_dir=0, vme_drive=0, transfer_active=0.
  - Counters reset to 0.
- Reset asserted mid-cycle forces all of the above immediately (asynchronous), including releasing the VME strobes.
- All outputs are registered. Relative to cpu_as sampled low with bus_acquired already high:
  - edge 1: ADDR.
  - edge 1+ADDR_SETUP_CYCLES: AS low.
  - one edge later: DS low.
- dtack low to DSACK low: 3 clocks (2 synchronizer, 1 FSM).
- Timeout: the counter counts clocks with DS asserted. cpu_berr asserts on the clock after the count equals TIMEOUT_CYCLES.
- berr and dtack arriving on the same synced clock: berr wins.
- RELEASE to IDLE: no earlier than 1 clock. A slave holding DTACK low stalls the FSM in RELEASE indefinitely.

## Test plan
- A24 supervisor data read, fc=5, siz=10, A=00, dtack 4 clocks after DS:
  - AM=0x3D, DS=00, write=1, dir=0.
  - cpu_dsack=01 until cpu_as rises; then AS and DS negate, then IDLE.
- A16 user byte write, fc=1, A0=1, siz=01: AM=0x29, DS=2'b10, write=0, d16_cross_oe low in ADDR, dir=1.
- A40 read: a40_cross_oe low; AM=0x34.
- No dtack: cpu_berr asserts exactly TIMEOUT_CYCLES+1 clocks after DS asserts; strobes are released after cpu_as rises.
- vme_berr and vme_dtack asserted on the same clock: cpu_berr asserts and cpu_dsack stays 11.
- Abort and reset:
  - cpu_as negated while in WAIT_BUS: no strobe ever asserts and the FSM returns to IDLE.
  - reset pulsed low during WAIT_ACK: all outputs return to their reset values with no clock edge.

Source files
------------

// File: rtl/vme_master_transfer.sv
// VME master data-transfer sequencer for the k30p controller.
//
// Runs one D16 VME master cycle (A16/A24/A40) once the address decoder
// requests a VME space and the arbiter has granted the bus. Drives the VME
// strobes, address modifier and transceiver enables, returns DSACK or bus
// error to the 68030, and releases the strobes before the next cycle.
//
// Ports (active-low unless noted):
//   clock, reset                       CPU clock; async active-low reset
//   request_vme_a16/a24/a40            active-high space selects (one-hot or zero)
//   bus_acquired                       active-high; arbiter owns the VME bus
//   cpu_as, cpu_ds, cpu_write          68030 strobes (cpu_write high = read)
//   cpu_siz[1:0], cpu_address[1:0]     68030 SIZ and A1:A0
//   cpu_fc[2:0]                        68030 function code
//   vme_dtack, vme_berr                asynchronous VME slave responses
//   cpu_dsack[1:0], cpu_berr           cycle termination to the CPU
//   vme_drive                          active-high master driver enable
//   vme_as_out, vme_ds_out[1:0]        VME AS and DS1:DS0
//   vme_lword_out, vme_write_out       VME LWORD and WRITE
//   vme_address_mod_out[5:0]           VME AM code
//   addr_low_oe, a40_cross_oe          address transceiver enables
//   d16_cross_oe, d16_cross_dir        data transceiver enable / direction (high = CPU to VME)
//   transfer_active                    active-high; arbiter holds BBSY while set
module vme_master_transfer #(
   parameter int unsigned ADDR_SETUP_CYCLES = 2,
   parameter int unsigned TIMEOUT_CYCLES    = 255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       request_vme_a16,
   input  logic       request_vme_a24,
   input  logic       request_vme_a40,
   input  logic       bus_acquired,
   input  logic       cpu_as,
   input  logic       cpu_ds,
   input  logic       cpu_write,
   input  logic [1:0] cpu_siz,
   input  logic [1:0] cpu_address,
   input  logic [2:0] cpu_fc,
   input  logic       vme_dtack,
   input  logic       vme_berr,
   output logic [1:0] cpu_dsack,
   output logic       cpu_berr,
   output logic       vme_drive,
   output logic       vme_as_out,
   output logic [1:0] vme_ds_out,
   output logic       vme_lword_out,
   output logic       vme_write_out,
   output logic [5:0] vme_address_mod_out,
   output logic       addr_low_oe,
   output logic       a40_cross_oe,
   output logic       d16_cross_oe,
   output logic       d16_cross_dir,
   output logic       transfer_active
);

   localparam logic [7:0] SetupLast = 8'(ADDR_SETUP_CYCLES - 1);
   localparam logic [7:0] Timeout   = 8'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      StIdle, StWaitBus, StAddr, StStrobe, StWaitAck, StAck, StError, StRelease
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   // Set from ADDR entry until IDLE; an abort from WAIT_BUS never sets it, so
   // that RELEASE path never drives the bus it does not own.
   logic       started_q, started_d;
   logic [5:0] am_q, am_d;
   logic [1:0] ds_q, ds_d;
   logic       write_q, write_d;
   logic       a40_q, a40_d;

   logic       dtack_meta_q, dtack_sync_q;
   logic       berr_meta_q, berr_sync_q;

   logic [5:0] am_enc;
   logic [1:0] ds_enc;

   logic [1:0] cpu_dsack_d;
   logic       cpu_berr_d, vme_as_d, addr_low_oe_d, a40_cross_oe_d;
   logic       d16_cross_oe_d, d16_cross_dir_d, vme_write_d;
   logic [1:0] vme_ds_d;
   logic [5:0] vme_am_d;

   logic unused_inputs;
   assign unused_inputs = ^{cpu_ds, cpu_address[1]};

   assign vme_lword_out = 1'b1;

   // Two-flop synchronizers; VME responses idle high.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dtack_meta_q <= 1'b1;
         dtack_sync_q <= 1'b1;
         berr_meta_q  <= 1'b1;
         berr_sync_q  <= 1'b1;
      end else begin
         dtack_meta_q <= vme_dtack;
         dtack_sync_q <= dtack_meta_q;
         berr_meta_q  <= vme_berr;
         berr_sync_q  <= berr_meta_q;
      end
   end

   // Address modifier and data strobe encodings from the current CPU cycle.
   always_comb begin
      am_enc = 6'h3D;
      if (request_vme_a16) begin
         am_enc = (cpu_fc == 3'd1 || cpu_fc == 3'd2) ? 6'h29 : 6'h2D;
      end else if (request_vme_a40) begin
         am_enc = 6'h34;
      end else begin
         case (cpu_fc)
            3'd5:    am_enc = 6'h3D;
            3'd6:    am_enc = 6'h3E;
            3'd1:    am_enc = 6'h39;
            3'd2:    am_enc = 6'h3A;
            default: am_enc = 6'h3D;
         endcase
      end

      if (cpu_address[0]) begin
         ds_enc = 2'b10;
      end else if (cpu_siz == 2'b01) begin
         ds_enc = 2'b01;
      end else begin
         ds_enc = 2'b00;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      started_d = started_q;
      am_d      = am_q;
      ds_d      = ds_q;
      write_d   = write_q;
      a40_d     = a40_q;

      unique case (state_q)
         StIdle: begin
            started_d = 1'b0;
            if (!cpu_as && (request_vme_a16 || request_vme_a24 || request_vme_a40)) begin
               state_d = StWaitBus;
            end
         end
         StWaitBus: begin
            if (cpu_as) begin
               state_d = StRelease;
            end else if (bus_acquired) begin
               state_d   = StAddr;
               cnt_d     = 8'd0;
               started_d = 1'b1;
               am_d      = am_enc;
               ds_d      = ds_enc;
               write_d   = cpu_write;
               a40_d     = request_vme_a40;
            end
         end
         StAddr: begin
            if (cpu_as) begin
               state_d = StRelease;
            end else if (cnt_q == SetupLast) begin
               state_d = StStrobe;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StStrobe: begin
            if (cpu_as) begin
               state_d = StRelease;
            end else begin
               state_d = StWaitAck;
               cnt_d   = 8'd0;
            end
         end
         StWaitAck: begin
            // berr has priority over a simultaneous dtack.
            if (cpu_as) begin
               state_d = StRelease;
            end else if (!berr_sync_q) begin
               state_d = StError;
            end else if (!dtack_sync_q) begin
               state_d = StAck;
            end else if (cnt_q == Timeout) begin
               state_d = StError;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StAck, StError: begin
            if (cpu_as) begin
               state_d = StRelease;
            end
         end
         StRelease: begin
            // A slave still holding DTACK/BERR stalls us here.
            if (dtack_sync_q && berr_sync_q) begin
               state_d   = StIdle;
               cnt_d     = 8'd0;
               started_d = 1'b0;
            end
         end
         default: begin
            state_d   = StIdle;
            started_d = 1'b0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register on the same
   // edge as the state change.
   always_comb begin
      cpu_dsack_d     = (state_d == StAck) ? 2'b01 : 2'b11;
      cpu_berr_d      = (state_d != StError);
      vme_as_d        = !(state_d inside {StStrobe, StWaitAck, StAck, StError});
      vme_ds_d        = (state_d inside {StWaitAck, StAck, StError}) ? ds_d : 2'b11;
      vme_write_d     = started_d ? write_d : 1'b1;
      vme_am_d        = started_d ? am_d : 6'h3F;
      addr_low_oe_d   = !started_d;
      a40_cross_oe_d  = !(started_d && a40_d);
      // Writes open the data path in ADDR; reads wait until the slave may drive.
      d16_cross_oe_d  = !(started_d &&
                          (!write_d || state_d inside {StWaitAck, StAck, StError, StRelease}));
      d16_cross_dir_d = started_d && !write_d;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q             <= StIdle;
         cnt_q               <= 8'd0;
         started_q           <= 1'b0;
         am_q                <= 6'h3F;
         ds_q                <= 2'b11;
         write_q             <= 1'b1;
         a40_q               <= 1'b0;
         cpu_dsack           <= 2'b11;
         cpu_berr            <= 1'b1;
         vme_drive           <= 1'b0;
         vme_as_out          <= 1'b1;
         vme_ds_out          <= 2'b11;
         vme_write_out       <= 1'b1;
         vme_address_mod_out <= 6'h3F;
         addr_low_oe         <= 1'b1;
         a40_cross_oe        <= 1'b1;
         d16_cross_oe        <= 1'b1;
         d16_cross_dir       <= 1'b0;
         transfer_active     <= 1'b0;
      end else begin
         state_q             <= state_d;
         cnt_q               <= cnt_d;
         started_q           <= started_d;
         am_q                <= am_d;
         ds_q                <= ds_d;
         write_q             <= write_d;
         a40_q               <= a40_d;
         cpu_dsack           <= cpu_dsack_d;
         cpu_berr            <= cpu_berr_d;
         vme_drive           <= started_d;
         vme_as_out          <= vme_as_d;
         vme_ds_out          <= vme_ds_d;
         vme_write_out       <= vme_write_d;
         vme_address_mod_out <= vme_am_d;
         addr_low_oe         <= addr_low_oe_d;
         a40_cross_oe        <= a40_cross_oe_d;
         d16_cross_oe        <= d16_cross_oe_d;
         d16_cross_dir       <= d16_cross_dir_d;
         transfer_active     <= started_d;
      end
   end

endmodule

// File: tb/tb_vme_master_transfer.sv
// Scoreboard bench for vme_master_transfer: the driver pushes the expected
// cycle (AM, DS, WRITE, space, response kind and latency) before issuing it;
// a negedge monitor pops and checks as the DUT presents each cycle.
module tb_vme_master_transfer;

   localparam int unsigned Setup = 2;
   localparam int unsigned Tmo   = 255;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       request_vme_a16 = 1'b0, request_vme_a24 = 1'b0, request_vme_a40 = 1'b0;
   logic       bus_acquired = 1'b1;
   logic       cpu_as = 1'b1, cpu_ds = 1'b1, cpu_write = 1'b1;
   logic [1:0] cpu_siz = 2'b00, cpu_address = 2'b00;
   logic [2:0] cpu_fc = 3'd5;
   logic       vme_dtack = 1'b1, vme_berr = 1'b1;
   logic [1:0] cpu_dsack;
   logic       cpu_berr, vme_drive, vme_as_out, vme_lword_out, vme_write_out;
   logic [1:0] vme_ds_out;
   logic [5:0] vme_address_mod_out;
   logic       addr_low_oe, a40_cross_oe, d16_cross_oe, d16_cross_dir, transfer_active;

   vme_master_transfer #(
      .ADDR_SETUP_CYCLES (Setup),
      .TIMEOUT_CYCLES    (Tmo)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .request_vme_a16     (request_vme_a16),
      .request_vme_a24     (request_vme_a24),
      .request_vme_a40     (request_vme_a40),
      .bus_acquired        (bus_acquired),
      .cpu_as              (cpu_as),
      .cpu_ds              (cpu_ds),
      .cpu_write           (cpu_write),
      .cpu_siz             (cpu_siz),
      .cpu_address         (cpu_address),
      .cpu_fc              (cpu_fc),
      .vme_dtack           (vme_dtack),
      .vme_berr            (vme_berr),
      .cpu_dsack           (cpu_dsack),
      .cpu_berr            (cpu_berr),
      .vme_drive           (vme_drive),
      .vme_as_out          (vme_as_out),
      .vme_ds_out          (vme_ds_out),
      .vme_lword_out       (vme_lword_out),
      .vme_write_out       (vme_write_out),
      .vme_address_mod_out (vme_address_mod_out),
      .addr_low_oe         (addr_low_oe),
      .a40_cross_oe        (a40_cross_oe),
      .d16_cross_oe        (d16_cross_oe),
      .d16_cross_dir       (d16_cross_dir),
      .transfer_active     (transfer_active)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [5:0]  am;
      logic [1:0]  ds;
      logic        wr;       // VME WRITE level: 1 = read
      logic        a40;
      logic        is_berr;
      int unsigned lat;      // DS assert edge to response edge
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic note_fail(input string name);
      checks++;
      fails++;
      $display("FAIL %s: bounded wait expired (t=%0t)", name, $time);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_dsack"}, cpu_dsack, 2'b11);
      chk({tag, "_cpu_berr"}, cpu_berr, 1'b1);
      chk({tag, "_as"}, vme_as_out, 1'b1);
      chk({tag, "_ds"}, vme_ds_out, 2'b11);
      chk({tag, "_lword"}, vme_lword_out, 1'b1);
      chk({tag, "_write"}, vme_write_out, 1'b1);
      chk({tag, "_am"}, vme_address_mod_out, 6'h3F);
      chk({tag, "_addr_low_oe"}, addr_low_oe, 1'b1);
      chk({tag, "_a40_oe"}, a40_cross_oe, 1'b1);
      chk({tag, "_d16_oe"}, d16_cross_oe, 1'b1);
      chk({tag, "_dir"}, d16_cross_dir, 1'b0);
      chk({tag, "_drive"}, vme_drive, 1'b0);
      chk({tag, "_active"}, transfer_active, 1'b0);
   endtask

   // Reference model: AM table by space (0=A16, 1=A24, 2=A40) and fc.
   function automatic logic [5:0] am_model(input int space, input int fc);
      logic user, prog;
      user = (fc == 1 || fc == 2);
      prog = (fc == 2 || fc == 6);
      if (space == 2) return 6'h34;
      if (space == 0) return user ? 6'h29 : 6'h2D;
      if (!(fc == 1 || fc == 2 || fc == 5 || fc == 6)) return 6'h3D;
      return 6'h38 | (user ? 6'h0 : 6'h4) | (prog ? 6'h2 : 6'h1);
   endfunction

   function automatic logic [1:0] ds_model(input logic a0, input logic [1:0] siz);
      if (a0) return 2'b10;          // DS0 only
      if (siz == 2'b01) return 2'b01; // DS1 only
      return 2'b00;
   endfunction

   // Monitor
   exp_t        cur;
   bit          have = 1'b0;
   int unsigned as_cyc = 0, ds_cyc = 0;
   logic        p_cpu_as = 1'b1, p_drive = 1'b0, p_as = 1'b1, p_ds = 1'b0;
   logic        p_resp = 1'b0, p_act = 1'b0;
   logic        resp_now, ds_now;

   always @(negedge clock or negedge reset) begin
      if (!reset) begin
         exp_q.delete();
         have     = 1'b0;
         p_cpu_as = 1'b1;
         p_drive  = 1'b0;
         p_as     = 1'b1;
         p_ds     = 1'b0;
         p_resp   = 1'b0;
         p_act    = 1'b0;
      end else begin
         resp_now = (cpu_dsack != 2'b11) || !cpu_berr;
         ds_now   = (vme_ds_out != 2'b11);
         if (p_cpu_as && !cpu_as) as_cyc = cyc;
         if (!p_drive && vme_drive) begin
            if (exp_q.size() == 0) begin
               chk("drive_without_txn", vme_drive, 1'b0);
            end else begin
               cur  = exp_q.pop_front();
               have = 1'b1;
               chk("drive_latency", cyc - as_cyc, 2);
               chk("am", vme_address_mod_out, cur.am);
               chk("write", vme_write_out, cur.wr);
               chk("dir", d16_cross_dir, !cur.wr);
               chk("d16_oe_in_addr", d16_cross_oe, cur.wr);
               chk("a40_oe", a40_cross_oe, !cur.a40);
               chk("addr_low_oe", addr_low_oe, 1'b0);
               chk("active", transfer_active, 1'b1);
               chk("lword", vme_lword_out, 1'b1);
            end
         end
         if (p_as && !vme_as_out) begin
            if (!have) chk("as_without_txn", vme_as_out, 1'b1);
            else begin
               chk("as_latency", cyc - as_cyc, Setup + 2);
               chk("ds_before_as", vme_ds_out, 2'b11);
            end
         end
         if (!p_ds && ds_now) begin
            ds_cyc = cyc;
            if (!have) chk("ds_without_txn", vme_ds_out, 2'b11);
            else begin
               chk("ds_latency", cyc - as_cyc, Setup + 3);
               chk("ds_value", vme_ds_out, cur.ds);
            end
         end
         if (!p_resp && resp_now && have) begin
            chk("resp_is_berr", !cpu_berr, cur.is_berr);
            chk("resp_dsack", cpu_dsack, cur.is_berr ? 2'b11 : 2'b01);
            chk("resp_latency", cyc - ds_cyc, cur.lat);
            chk("resp_d16_oe", d16_cross_oe, 1'b0);
         end
         if (resp_now && have) begin
            chk("resp_holds_as", vme_as_out, 1'b0);
            chk("resp_holds_ds", vme_ds_out, cur.ds);
         end
         if (p_act && !transfer_active && have) begin
            check_idle("back_to_idle");
            have = 1'b0;
         end
         p_cpu_as = cpu_as;
         p_drive  = vme_drive;
         p_as     = vme_as_out;
         p_ds     = ds_now;
         p_resp   = resp_now;
         p_act    = transfer_active;
      end
   end

   // Driver
   task automatic start_cycle(input int space, input int fc, input logic [1:0] siz,
                              input logic a0, input logic wr);
      @(posedge clock);
      #1;
      request_vme_a16 = (space == 0);
      request_vme_a24 = (space == 1);
      request_vme_a40 = (space == 2);
      cpu_fc          = 3'(fc);
      cpu_siz         = siz;
      cpu_address     = {1'b0, a0};
      cpu_write       = wr;
      cpu_as          = 1'b0;
      cpu_ds          = 1'b0;
   endtask

   task automatic end_cpu_cycle();
      @(posedge clock);
      #1;
      cpu_as          = 1'b1;
      cpu_ds          = 1'b1;
      request_vme_a16 = 1'b0;
      request_vme_a24 = 1'b0;
      request_vme_a40 = 1'b0;
   endtask

   task automatic wait_ds(output bit ok);
      int n = 0;
      ok = 1'b1;
      while (vme_ds_out == 2'b11 && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) begin
         note_fail("wait_ds");
         ok = 1'b0;
      end
   endtask

   // d/b: clocks after DS assert at which dtack/berr go low (0 = never).
   task automatic run_txn(input int space, input int fc, input logic [1:0] siz,
                          input logic a0, input logic wr, input int d, input int b);
      exp_t e;
      bit   ok;
      int   n;
      e.am  = am_model(space, fc);
      e.ds  = ds_model(a0, siz);
      e.wr  = wr;
      e.a40 = (space == 2);
      if (b != 0 && (d == 0 || b <= d)) begin
         e.is_berr = 1'b1;
         e.lat     = b + 3;
      end else if (d != 0) begin
         e.is_berr = 1'b0;
         e.lat     = d + 3;
      end else begin
         e.is_berr = 1'b1;
         e.lat     = Tmo + 1;
      end
      exp_q.push_back(e);
      start_cycle(space, fc, siz, a0, wr);
      wait_ds(ok);
      if (ok) begin
         for (int k = 1; k <= ((d > b) ? d : b); k++) begin
            @(posedge clock);
            #1;
            if (k == d) vme_dtack = 1'b0;
            if (k == b) vme_berr = 1'b0;
         end
         n = 0;
         while (cpu_dsack == 2'b11 && cpu_berr && n < int'(Tmo) + 20) begin
            @(negedge clock);
            n++;
         end
         if (n >= int'(Tmo) + 20) note_fail("wait_response");
         repeat (2) @(posedge clock);
      end
      end_cpu_cycle();
      if (!vme_dtack || !vme_berr) begin
         // Slave still holding its response: the master must sit in RELEASE.
         repeat (3) @(posedge clock);
         #1;
         chk("release_stall", transfer_active, 1'b1);
      end
      vme_dtack = 1'b1;
      vme_berr  = 1'b1;
      n = 0;
      while (transfer_active && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (n >= 20) note_fail("wait_idle");
      repeat (2) @(posedge clock);
   endtask

   initial begin
      bit ok;
      #23;
      check_idle("reset");
      reset = 1'b1;
      repeat (2) @(posedge clock);

      run_txn(1, 5, 2'b10, 1'b0, 1'b1, 4, 0);   // A24 supervisor data read
      run_txn(0, 1, 2'b01, 1'b1, 1'b0, 3, 0);   // A16 user byte write
      run_txn(2, 5, 2'b00, 1'b0, 1'b1, 2, 0);   // A40 read
      run_txn(1, 6, 2'b10, 1'b0, 1'b1, 0, 0);   // no dtack: timeout
      run_txn(1, 2, 2'b01, 1'b0, 1'b0, 3, 3);   // berr and dtack together

      // Abort while waiting for the bus.
      bus_acquired = 1'b0;
      start_cycle(1, 5, 2'b10, 1'b0, 1'b1);
      repeat (3) @(posedge clock);
      end_cpu_cycle();
      repeat (4) @(posedge clock);
      #1;
      chk("abort_as", vme_as_out, 1'b1);
      chk("abort_ds", vme_ds_out, 2'b11);
      chk("abort_active", transfer_active, 1'b0);
      bus_acquired = 1'b1;
      run_txn(0, 5, 2'b10, 1'b0, 1'b1, 1, 0);

      // Asynchronous reset mid WAIT_ACK.
      begin
         exp_t e;
         e.am = am_model(1, 1); e.ds = ds_model(1'b0, 2'b10); e.wr = 1'b1;
         e.a40 = 1'b0; e.is_berr = 1'b0; e.lat = 0;
         exp_q.push_back(e);
      end
      start_cycle(1, 1, 2'b10, 1'b0, 1'b1);
      wait_ds(ok);
      repeat (5) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      check_idle("async_reset");
      cpu_as          = 1'b1;
      cpu_ds          = 1'b1;
      request_vme_a24 = 1'b0;
      #1;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      run_txn(1, 5, 2'b00, 1'b1, 1'b0, 2, 0);

      for (int i = 0; i < 20; i++) begin
         int space, fc, mode, d, b;
         space = int'($urandom_range(0, 2));
         fc    = int'($urandom_range(0, 7));
         mode  = int'($urandom_range(0, 5));
         d     = 0;
         b     = 0;
         if (mode == 1) b = int'($urandom_range(1, 6));
         else if (mode == 2) begin
            d = int'($urandom_range(1, 6));
            b = int'($urandom_range(1, 6));
         end else if (mode >= 3) d = int'($urandom_range(1, 8));
         run_txn(space, fc, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), d, b);
      end

      if (exp_q.size() != 0) chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
